// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared definitions for the RV32M multiply/divide unit.
//   - MD_XLEN      : operand/result width (only 32 is supported)
//   - ALU_MUL..ALU_REMU : 5-bit ALU opcodes emitted by decode for M-extension ops
//   - md_state_t   : controller state encoding
//   - cond_neg32() : two's-complement negate when a flag is set
package mul_div_unit_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHU  = 5'b01010;
    localparam logic [4:0] ALU_MULHSU = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        FIX     = 2'd2,
        SPECIAL = 2'd3
    } md_state_t;

    function automatic logic [MD_XLEN-1:0] cond_neg32(input logic neg,
                                                      input logic [MD_XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle between the EX pipeline and the
// multiply/divide unit.
//   master (pipeline): drives START, ALU_OPCODE, OPERAND1, OPERAND2, FLUSH;
//                      receives BUSY, DONE, RESULT
//   slave  (unit)    : the mirror image
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic               START;
    logic [4:0]         ALU_OPCODE;
    logic [MD_XLEN-1:0] OPERAND1;
    logic [MD_XLEN-1:0] OPERAND2;
    logic               FLUSH;
    logic               BUSY;
    logic               DONE;
    logic [MD_XLEN-1:0] RESULT;

    modport master (
        output START, ALU_OPCODE, OPERAND1, OPERAND2, FLUSH,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, ALU_OPCODE, OPERAND1, OPERAND2, FLUSH,
        output BUSY, DONE, RESULT
    );

endinterface

// File: rtl/mul_div_unit_step.sv
// muldiv_step: one combinational radix-2 iteration on the shared 65-bit
// accumulator.
//   is_div  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_in  : multiply -> {partial product high (33b), multiplier remainder (32b)}
//             divide   -> {partial remainder (33b), dividend/quotient (32b)}
//   operand : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_out : accumulator after this iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN:0]   acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN:0]   acc_out
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        sum     = acc_in[2*XLEN:XLEN] + (acc_in[0] ? {1'b0, operand} : '0);
        // Next dividend bit enters the remainder from the top of the low half.
        shifted = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, operand};
        acc_out = '0;
        if (!is_div) begin
            acc_out = {1'b0, sum, acc_in[XLEN-1:1]};
        end else if (!diff[XLEN+1]) begin
            acc_out = {diff[XLEN:0], acc_in[XLEN-2:0], 1'b1};
        end else begin
            acc_out = {shifted, acc_in[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, with sign correction in FIX. Divide-by-zero and signed overflow take
// a two-cycle SPECIAL path.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous active-high reset
//   md    : mul_div_unit_if.slave (START/ALU_OPCODE/OPERAND1/OPERAND2/FLUSH in,
//           BUSY/DONE/RESULT out)
// Build option: define MULDIV_FAST_MUL_EN to compute multiplies with a
// single-cycle 33x33 signed multiplier (IDLE -> FIX, 2-cycle latency).
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN      = MD_XLEN,
    parameter int ITER_BITS = 5
) (
    input logic            CLK,
    input logic            RESET,
    mul_div_unit_if.slave  md
);
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    md_state_t              state;
    logic [ITER_BITS-1:0]   cnt;
    logic [2:0]             op;
    logic [2*XLEN:0]        acc;
    logic [XLEN-1:0]        opnd;
    logic                   neg_res;
    logic                   neg_rem;

    logic [2:0]             new_op;
    logic                   new_div, op_valid, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]        a_mag, b_mag, special_val;
    logic                   div_zero, div_ovf;
    logic [2*XLEN:0]        step_out;
    logic [2*XLEN-1:0]      prod_fix;
    logic [2*XLEN-1:0]      fast_prod;
    logic [XLEN-1:0]        fix_res;

    // Request decode; low three opcode bits index the M-extension operation.
    assign new_op   = md.ALU_OPCODE[2:0];
    assign op_valid = (md.ALU_OPCODE[4:3] == 2'b01);
    assign new_div  = new_op[2];
    // OPERAND1 signed for MUL/MULH/MULHSU/DIV/REM; OPERAND2 signed for MUL/MULH/DIV/REM.
    assign a_signed = (new_op == 3'b000) || (new_op == 3'b001) || (new_op == 3'b011) ||
                      (new_op == 3'b100) || (new_op == 3'b110);
    assign b_signed = (new_op == 3'b000) || (new_op == 3'b001) ||
                      (new_op == 3'b100) || (new_op == 3'b110);
    assign a_neg    = a_signed && md.OPERAND1[XLEN-1];
    assign b_neg    = b_signed && md.OPERAND2[XLEN-1];
    assign a_mag    = cond_neg32(a_neg, md.OPERAND1);
    assign b_mag    = cond_neg32(b_neg, md.OPERAND2);

    assign div_zero = new_div && (md.OPERAND2 == '0);
    assign div_ovf  = new_div && !new_op[0] && (md.OPERAND1 == 32'h8000_0000) &&
                      (md.OPERAND2 == 32'hFFFF_FFFF);
    // new_op[1] distinguishes remainder from quotient among divide opcodes.
    assign special_val = div_zero ? (new_op[1] ? md.OPERAND1 : 32'hFFFF_FFFF)
                                  : (new_op[1] ? 32'h0000_0000 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
    // 33x33 signed product; sign-extended to 64 bits so the low 64 are exact.
    logic [2*XLEN-1:0] fa64, fb64;
    assign fa64      = {{XLEN{a_signed && md.OPERAND1[XLEN-1]}}, md.OPERAND1};
    assign fb64      = {{XLEN{b_signed && md.OPERAND2[XLEN-1]}}, md.OPERAND2};
    assign fast_prod = fa64 * fb64;
`else
    assign fast_prod = '0;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op[2]),
        .acc_in  (acc),
        .operand (opnd),
        .acc_out (step_out)
    );

    // Sign correction and output select used in FIX.
    always_comb begin
        prod_fix = neg_res ? (~acc[2*XLEN-1:0] + 1'b1) : acc[2*XLEN-1:0];
        fix_res  = '0;
        case (op)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = cond_neg32(neg_res, acc[XLEN-1:0]);
            default:                fix_res = cond_neg32(neg_rem, acc[2*XLEN-1:XLEN]);
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            md.BUSY   <= 1'b0;
            md.DONE   <= 1'b0;
            md.RESULT <= '0;
        end else begin
            md.DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (md.START && !md.FLUSH && op_valid) begin
                        op      <= new_op;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg && new_div;
                        cnt     <= ITER_BITS'(XLEN - 1);
                        md.BUSY <= 1'b1;
                        if (div_zero || div_ovf) begin
                            // Special result parked in the low half for SPECIAL.
                            acc   <= {{(XLEN+1){1'b0}}, special_val};
                            state <= SPECIAL;
                        end else if (FAST_MUL && !new_div) begin
                            acc     <= {1'b0, fast_prod};
                            neg_res <= 1'b0;
                            state   <= FIX;
                        end else begin
                            acc   <= {{(XLEN+1){1'b0}}, new_div ? a_mag : b_mag};
                            opnd  <= new_div ? b_mag : a_mag;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (md.FLUSH) begin
                        state   <= IDLE;
                        md.BUSY <= 1'b0;
                    end else begin
                        acc <= step_out;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= FIX;
                    end
                end
                FIX: begin
                    state   <= IDLE;
                    md.BUSY <= 1'b0;
                    if (!md.FLUSH) begin
                        md.RESULT <= fix_res;
                        md.DONE   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    md.BUSY <= 1'b0;
                    if (!md.FLUSH) begin
                        md.RESULT <= acc[XLEN-1:0];
                        md.DONE   <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_LAT  = 34;
    localparam int MUL_BUSY = 33;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    mul_div_unit_if bus();

    mul_div_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .md    (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        bus.START      = 1'b1;
        bus.ALU_OPCODE = opc;
        bus.OPERAND1   = a;
        bus.OPERAND2   = b;
    endtask

    // Call with START already driven at a negedge; returns at the negedge
    // where DONE is seen (or after the cycle budget). A nonzero poke re-raises
    // START with a different multiply on that cycle.
    task automatic wait_done(input int poke, output logic [31:0] res,
                             output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (lat == poke) begin
                start_op(ALU_MUL, 32'd2, 32'd3);
            end else begin
                bus.START = 1'b0;
            end
            if (bus.BUSY) busy_n++;
        end while (!bus.DONE && lat < 200);
        res = bus.RESULT;
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (bus.DONE || bus.BUSY) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic run(input string tag, input logic [4:0] opc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] r;
        int lat, bn;
        @(negedge CLK);
        start_op(opc, a, b);
        wait_done(0, r, lat, bn);
        check({tag, "_res"}, r, exp);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] r;
        int lat, bn;

        bus.START = 1'b0;
        bus.ALU_OPCODE = 5'd0;
        bus.OPERAND1 = '0;
        bus.OPERAND2 = '0;
        bus.FLUSH = 1'b0;

        #2 RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_result", bus.RESULT, 32'd0);
        RESET = 1'b0;

        // MUL 7 * -3 with latency, busy length and one-cycle DONE
        @(negedge CLK);
        start_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_done(0, r, lat, bn);
        check("mul_res", r, 32'hFFFF_FFEB);
        check("mul_lat", 32'(lat), 32'(MUL_LAT));
        check("mul_busy", 32'(bn), 32'(MUL_BUSY));
        check("mul_busy_in_done", 32'(bus.BUSY), 32'd0);
        @(negedge CLK);
        check("mul_done_pulse", 32'(bus.DONE), 32'd0);

        // Back-to-back high-word multiplies, START in each DONE cycle
        start_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, r, lat, bn);
        check("mulhu_res", r, 32'hFFFF_FFFE);
        check("mulhu_lat", 32'(lat), 32'(MUL_LAT));
        start_op(ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, r, lat, bn);
        check("mulh_res", r, 32'h0000_0000);
        check("mulh_lat", 32'(lat), 32'(MUL_LAT));
        start_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, r, lat, bn);
        check("mulhsu_res", r, 32'hFFFF_FFFF);
        check("mulhsu_lat", 32'(lat), 32'(MUL_LAT));
        bus.START = 1'b0;

        // Divides of -7 by 2
        run("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run("rem", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run("remu", ALU_REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 34);
        run("divu", ALU_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);

        // FLUSH on the 10th CALC cycle of a divide
        @(negedge CLK);
        start_op(ALU_DIV, 32'd100, 32'd7);
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (9) @(negedge CLK);
        check("flush_busy_before", 32'(bus.BUSY), 32'd1);
        bus.FLUSH = 1'b1;
        @(negedge CLK);
        bus.FLUSH = 1'b0;
        check("flush_busy_after", 32'(bus.BUSY), 32'd0);
        check("flush_result_hold", bus.RESULT, 32'h7FFF_FFFC);
        quiet_cycles("flush_no_done", 40);
        check("flush_result_hold2", bus.RESULT, 32'h7FFF_FFFC);
        run("mul_after_flush", ALU_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT);

        // Special divides
        run("div_by0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run("rem_by0", ALU_REM, 32'd5, 32'd0, 32'd5, 2);
        run("divu_by0", ALU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 2);
        run("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

        // Non-M opcode is ignored
        @(negedge CLK);
        start_op(5'b00000, 32'd1, 32'd1);
        @(negedge CLK);
        bus.START = 1'b0;
        check("badop_busy", 32'(bus.BUSY), 32'd0);
        quiet_cycles("badop_quiet", 10);

        // FLUSH together with START in IDLE drops the request
        @(negedge CLK);
        start_op(ALU_MUL, 32'd5, 32'd5);
        bus.FLUSH = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.FLUSH = 1'b0;
        check("flush_start_busy", 32'(bus.BUSY), 32'd0);
        quiet_cycles("flush_start_quiet", 10);

        // START while busy is ignored
        @(negedge CLK);
        start_op(ALU_MUL, 32'd6, 32'd7);
        wait_done(5, r, lat, bn);
        check("busy_start_res", r, 32'd42);
        check("busy_start_lat", 32'(lat), 32'(MUL_LAT));
        quiet_cycles("busy_start_quiet", 10);

        // Asynchronous reset mid-CALC
        @(negedge CLK);
        start_op(ALU_DIV, 32'd1000, 32'd3);
        repeat (5) @(negedge CLK);
        bus.START = 1'b0;
        check("pre_reset_busy", 32'(bus.BUSY), 32'd1);
        RESET = 1'b1;
        #1;
        check("reset_busy", 32'(bus.BUSY), 32'd0);
        check("reset_done", 32'(bus.DONE), 32'd0);
        check("reset_result", bus.RESULT, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        quiet_cycles("reset_no_done", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
